huffman_gen: RTL
================

HUFFMAN_GEN -- requirements
Module: huffman_gen

Interface
REQ-001 Parameter NSYM, default 6: number of symbols, legal range 2..16; symbol values are 1..NSYM.
REQ-002 Parameter CNT_W, default 8: per-symbol occurrence counter width.
REQ-003 Parameter CODE_W, default 8: per-symbol code/mask lane width; must be >= NSYM-1, enforced by an elaboration-time check.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 gray_valid  in  1  qualifies gray_data; a high run forms one frame.
REQ-007 gray_data  in  8  symbol value.
REQ-008 CNT_valid  out  1  per-merge trace strobe.
REQ-009 CNT  out  NSYM*CNT_W  sorted count list, entry 0 (smallest) in the LSB lane.
REQ-010 code_valid  out  1  one-cycle strobe that qualifies HC and M.
REQ-011 HC  out  NSYM*CODE_W  codes; lane HC[CODE_W*(k-1) +: CODE_W] holds symbol k.
REQ-012 M  out  NSYM*CODE_W  masks, same lane layout as HC; ones mark valid code bits.
REQ-013 sym_err  out  1  sticky flag: an out-of-range symbol was seen in the current frame.
REQ-014 busy  out  1  high in every state other than IDLE.

Function
REQ-015 FSM states: IDLE, READ, SORT, MERGE, OUT.
REQ-016 FSM transitions:
- IDLE->READ when gray_valid=1.
- READ stays in READ while gray_valid=1; READ->SORT when gray_valid=0.
- SORT->MERGE always.
- MERGE->SORT while live nodes > 1 after the merge; otherwise MERGE->OUT.
- OUT->IDLE always.
REQ-017 Counting:
- Each sampled valid symbol in 1..NSYM increments its counter.
- Counters saturate at 2^CNT_W-1.
- Values 0 or >NSYM are discarded and set sym_err.
REQ-018 Frame start: entering READ from IDLE clears all counters, codes, masks and sym_err.
REQ-019 Ordering: SORT orders live nodes ascending by count. Ties go lowest node id first. Symbols with a zero count are live nodes.
REQ-020 Merge:
- MERGE combines sorted entries 0 and 1 into a new node.
- The new node id is NSYM+1+k, where k is the merge index starting at 0.
- The new node count is the sum of the two counts, saturating at 2^CNT_W-1.
REQ-021 Code-bit assignment on each merge:
- Every leaf under entry 0 receives code bit 1; every leaf under entry 1 receives code bit 0.
- The bit goes at that leaf's current depth pointer, starting at bit 0.
- The leaf's mask bit at that position is set and its pointer increments.
- Bit (len-1) is therefore the root-side bit.
REQ-022 Exactly NSYM-1 merges occur.
REQ-023 Latency: code_valid is high for exactly one cycle, 2*NSYM cycles after the edge at which gray_valid is sampled low.
REQ-024 HC and M are valid only while code_valid=1 and are 0 otherwise.
REQ-025 gray_valid is ignored in SORT, MERGE and OUT; a new frame is accepted from IDLE only.
REQ-026 All counts zero: codes are still built by the tie rule; the result is deterministic.

Reset
REQ-027 Reset forces the FSM to IDLE immediately, including mid-frame or mid-merge.
REQ-028 During reset, CNT_valid, CNT, code_valid, HC, M, sym_err and busy are all 0.
REQ-029 No partial result is emitted after reset deasserts.

Configuration
REQ-030 With macro HUFFMAN_CNT_TRACE_EN defined: CNT_valid pulses in every MERGE cycle, and CNT carries that cycle's sorted count list.
REQ-031 Without HUFFMAN_CNT_TRACE_EN: CNT_valid and CNT are held at 0, and no trace registers are generated.

Structure
REQ-032 Shared package huffman_pkg holds:
- the FSM state enum;
- the node-id width function clog2(2*NSYM);
- the retired-node sentinel: count all-ones, id all-ones, always sorting last.
REQ-033 Sub-module huffman_sort holds the combinational stable ascending sort of NSYM (id, count) pairs with the tie rule. It is the only instance.

Verification
REQ-034 Scenario NSYM=6, frame with counts 1:5, 2:4, 3:3, 4:2, 5:1, 6:1. Required response:
- HC=0x04_05_03_03_02_00 and M=0x0F_0F_07_03_03_03;
- code_valid high 12 cycles after gray_valid is sampled low.
REQ-035 Scenario: a frame containing symbols 0 and 9. Required response: the symbols are not counted, sym_err=1 until the next frame starts, and codes still come out.
REQ-036 Scenario: 300 copies of symbol 2 with CNT_W=8. Required response: the count saturates at 255 with no wrap, visible on CNT when the trace is enabled.
REQ-037 Scenario: reset asserted during the third MERGE. Required response: all outputs are 0 the next cycle, and there is no code_valid pulse until a new frame arrives.
REQ-038 Scenario: trace enabled, NSYM=6. Required response: exactly 5 CNT_valid pulses, and each CNT list is ascending.
REQ-039 Scenario: NSYM=2 with counts 3,3. Required response: HC=0x00_01 and M=0x01_01.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and helpers for the Huffman code generator.
package huffman_pkg;

  typedef enum logic [2:0] {IDLE, READ, SORT, MERGE, OUT} state_t;

  // Node ids run 1..2*NSYM-1 (leaves, then merged nodes).
  function automatic int node_id_w(input int nsym);
    return $clog2(2 * nsym);
  endfunction

  // Retired-node sentinel: all-ones count and id, so it always sorts last.
  localparam logic [63:0] SENTINEL = '1;

endpackage

// File: rtl/huffman_sort.sv
// Combinational stable ascending sort of (id, count) pairs; ties go to the lower id.
module huffman_sort import huffman_pkg::*; #(
  parameter int NSYM  = 6,
  parameter int CNT_W = 8,
  parameter int IDW   = 4
) (
  input  logic [NSYM-1:0][IDW-1:0]   id_in,
  input  logic [NSYM-1:0][CNT_W-1:0] cnt_in,
  output logic [NSYM-1:0][IDW-1:0]   id_out,
  output logic [NSYM-1:0][CNT_W-1:0] cnt_out
);
  localparam int RW = $clog2(NSYM);

  logic [NSYM-1:0][RW-1:0] rank;

  // Rank on the {count, id} key; equal keys (sentinels) fall back to position.
  always_comb begin
    for (int i = 0; i < NSYM; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NSYM; j++)
        if (({cnt_in[j], id_in[j]} < {cnt_in[i], id_in[i]}) ||
            (({cnt_in[j], id_in[j]} == {cnt_in[i], id_in[i]}) && (j < i)))
          rank[i] = rank[i] + 1'b1;
    end
  end

  always_comb begin
    id_out  = '0;
    cnt_out = '0;
    for (int r = 0; r < NSYM; r++)
      for (int i = 0; i < NSYM; i++)
        if (rank[i] == RW'(r)) begin
          id_out[r]  = id_in[i];
          cnt_out[r] = cnt_in[i];
        end
  end

endmodule

// File: rtl/huffman_gen.sv
// Frame-based Huffman code generator: count symbols, then sort/merge to build codes.
// Optional merge trace on CNT/CNT_valid via HUFFMAN_CNT_TRACE_EN.
module huffman_gen import huffman_pkg::*; #(
  parameter int NSYM   = 6,
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gray_valid,
  input  logic [7:0]               gray_data,
  output logic                     CNT_valid,
  output logic [NSYM*CNT_W-1:0]    CNT,
  output logic                     code_valid,
  output logic [NSYM*CODE_W-1:0]   HC,
  output logic [NSYM*CODE_W-1:0]   M,
  output logic                     sym_err,
  output logic                     busy
);
  localparam int IDW = node_id_w(NSYM);
  localparam int DW  = $clog2(CODE_W + 1);
  localparam int KW  = $clog2(NSYM);
  localparam logic [IDW-1:0]   SENT_ID  = SENTINEL[IDW-1:0];
  localparam logic [CNT_W-1:0] SENT_CNT = SENTINEL[CNT_W-1:0];

  if (CODE_W < NSYM - 1) begin : g_code_w_chk
    $error("huffman_gen: CODE_W must be >= NSYM-1");
  end
  if (NSYM < 2 || NSYM > 16) begin : g_nsym_chk
    $error("huffman_gen: NSYM must be in 2..16");
  end

  state_t state, nstate;

  logic [NSYM-1:0][CNT_W-1:0]  cnt, node_cnt, srt_cnt, s_cnt;
  logic [NSYM-1:0][IDW-1:0]    node_id, srt_id, s_id, grp;
  logic [NSYM-1:0][CODE_W-1:0] code, mask, hc_hold, m_hold;
  logic [NSYM-1:0][DW-1:0]     dep;
  logic [KW-1:0]               mcnt;
  logic [1:0]                  vld_pipe;
  logic [CNT_W:0]              sum;
  logic [CNT_W-1:0]            sum_sat;
  logic [IDW-1:0]              new_id;
  logic                        sym_ok;

  huffman_sort #(.NSYM(NSYM), .CNT_W(CNT_W), .IDW(IDW)) u_sort (
    .id_in  (node_id),
    .cnt_in (node_cnt),
    .id_out (s_id),
    .cnt_out(s_cnt)
  );

  assign sym_ok  = (gray_data != 8'd0) && (gray_data <= 8'(NSYM));
  assign sum     = {1'b0, srt_cnt[0]} + {1'b0, srt_cnt[1]};
  assign sum_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  assign new_id  = IDW'(NSYM + 1) + IDW'(mcnt);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nstate;

  always_comb begin
    nstate = state;
    busy   = (state != IDLE);
    unique case (state)
      IDLE:    if (gray_valid) nstate = READ;
      READ:    if (!gray_valid) nstate = SORT;
      SORT:    nstate = MERGE;
      MERGE:   nstate = (mcnt == KW'(NSYM - 2)) ? OUT : SORT;
      OUT:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0; node_cnt <= '0; srt_cnt <= '0; node_id <= '0; srt_id <= '0;
      grp <= '0; code <= '0; mask <= '0; dep <= '0; mcnt <= '0;
      hc_hold <= '0; m_hold <= '0; vld_pipe <= '0; sym_err <= 1'b0;
    end else begin
      // Two-stage strobe places code_valid 2*NSYM edges after the frame ends.
      vld_pipe <= {vld_pipe[0], state == OUT};
      unique case (state)
        IDLE: if (gray_valid) begin
          code <= '0; mask <= '0; dep <= '0;
          sym_err <= !sym_ok;
          for (int k = 0; k < NSYM; k++)
            cnt[k] <= (gray_data == 8'(k + 1)) ? CNT_W'(1) : '0;
        end
        READ: if (gray_valid) begin
          if (!sym_ok) sym_err <= 1'b1;
          for (int k = 0; k < NSYM; k++)
            if (gray_data == 8'(k + 1) && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
        end else begin
          node_cnt <= cnt;
          mcnt     <= '0;
          for (int k = 0; k < NSYM; k++) begin
            node_id[k] <= IDW'(k + 1);
            grp[k]     <= IDW'(k + 1);
          end
        end
        SORT: begin
          srt_id  <= s_id;
          srt_cnt <= s_cnt;
        end
        MERGE: begin
          node_id     <= srt_id;
          node_cnt    <= srt_cnt;
          node_id[0]  <= new_id;
          node_cnt[0] <= sum_sat;
          node_id[1]  <= SENT_ID;
          node_cnt[1] <= SENT_CNT;
          mcnt        <= mcnt + 1'b1;
          // Leaves under entry 0 get a 1, under entry 1 a 0, at their depth pointer.
          for (int k = 0; k < NSYM; k++)
            if (grp[k] == srt_id[0] || grp[k] == srt_id[1]) begin
              for (int b = 0; b < CODE_W; b++)
                if (dep[k] == DW'(b)) begin
                  code[k][b] <= (grp[k] == srt_id[0]);
                  mask[k][b] <= 1'b1;
                end
              dep[k] <= dep[k] + 1'b1;
              grp[k] <= new_id;
            end
        end
        OUT: begin
          hc_hold <= code;
          m_hold  <= mask;
        end
        default: ;
      endcase
    end

  assign code_valid = vld_pipe[1];
  assign HC         = code_valid ? hc_hold : '0;
  assign M          = code_valid ? m_hold  : '0;

`ifdef HUFFMAN_CNT_TRACE_EN
  assign CNT_valid = (state == MERGE);
  assign CNT       = CNT_valid ? srt_cnt : '0;
`else
  assign CNT_valid = 1'b0;
  assign CNT       = '0;
`endif

endmodule
